// File: rtl/sr_drive_pkg.sv
// Shared types and width helpers for the SR flip-flop drive controller.
package sr_drive_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SET_HOLD = 2'd1,
      ST_CLR_HOLD = 2'd2,
      ST_VERIFY   = 2'd3
   } drive_state_t;

   localparam int DEB_CYCLES_DEF  = 4;
   localparam int HOLD_CYCLES_DEF = 2;
   localparam int DEB_W  = $clog2(DEB_CYCLES_DEF + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES_DEF + 1);

   // Counter width able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sr_drive_if.sv
// Button inputs, flip-flop drive/feedback and status flags of the drive controller.
interface sr_drive_if;
   logic set_btn;
   logic clr_btn;
   logic q_fb;
   logic s;
   logic r;
   logic busy;
   logic conflict;
   logic miss;
   logic err;

   modport master (
      output set_btn, clr_btn, q_fb,
      input  s, r, busy, conflict, miss, err
   );

   modport slave (
      input  set_btn, clr_btn, q_fb,
      output s, r, busy, conflict, miss, err
   );
endinterface

// File: rtl/sr_drive_ctrl_btn_debounce.sv
// Two-flop synchroniser, debounce counter and rising-edge press detector for one button.
module btn_debounce
   import sr_drive_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CW = cnt_width(DEB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   // The new level is taken when the counter already holds DEB_CYCLES and the
   // inputs still differ, so a change must persist for DEB_CYCLES+1 samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 != level) begin
            if (cnt == CW'(DEB_CYCLES)) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Debounced set/clear buttons to fixed-width s/r pulses for SR_FF, never s=r=1.
// Define SR_DRIVE_VERIFY_EN to build the q_fb read-back check and live err flag.
//
//   state       | meaning
//   ST_IDLE     | waiting for a set or clear request
//   ST_SET_HOLD | s asserted for HOLD_CYCLES cycles
//   ST_CLR_HOLD | r asserted for HOLD_CYCLES cycles
//   ST_VERIFY   | compare q_fb with the value just written
module sr_drive_ctrl
   import sr_drive_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic     clk,
   input  logic     rst,
   sr_drive_if.slave bus
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

   drive_state_t  state;
   logic [HW-1:0] hold_cnt;
   logic          s_q, r_q, busy_q, conflict_q, miss_q, err_q;
   logic          verify_exp;
   logic          set_level, clr_level;
   logic          set_press, clr_press;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.set_btn),
      .level (set_level),
      .press (set_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (bus.clr_btn),
      .level (clr_level),
      .press (clr_press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         hold_cnt   <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
         miss_q     <= 1'b0;
         err_q      <= 1'b0;
         verify_exp <= 1'b0;
      end else begin
         conflict_q <= 1'b0;
         miss_q     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (set_press && clr_press) begin
                  conflict_q <= 1'b1;
               end else if (set_press) begin
                  state      <= ST_SET_HOLD;
                  s_q        <= 1'b1;
                  busy_q     <= 1'b1;
                  hold_cnt   <= HOLD_INIT;
                  verify_exp <= 1'b1;
               end else if (clr_press) begin
                  state      <= ST_CLR_HOLD;
                  r_q        <= 1'b1;
                  busy_q     <= 1'b1;
                  hold_cnt   <= HOLD_INIT;
                  verify_exp <= 1'b0;
               end
            end
            ST_SET_HOLD, ST_CLR_HOLD: begin
               miss_q <= set_press | clr_press;
               if (hold_cnt == '0) begin
                  s_q <= 1'b0;
                  r_q <= 1'b0;
`ifdef SR_DRIVE_VERIFY_EN
                  state <= ST_VERIFY;
`else
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
`endif
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
`ifdef SR_DRIVE_VERIFY_EN
            ST_VERIFY: begin
               miss_q <= set_press | clr_press;
               if (bus.q_fb != verify_exp) err_q <= 1'b1;
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
`endif
            default: begin
               state  <= ST_IDLE;
               s_q    <= 1'b0;
               r_q    <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Debounced levels are only consumed through their press strobes.
   logic [1:0] unused_levels;
   assign unused_levels = {set_level, clr_level};

`ifndef SR_DRIVE_VERIFY_EN
   logic [1:0] unused_fb;
   assign unused_fb = {bus.q_fb, verify_exp};
`endif

   assign bus.s        = s_q;
   assign bus.r        = r_q;
   assign bus.busy     = busy_q;
   assign bus.conflict = conflict_q;
   assign bus.miss     = miss_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Scoreboard bench for sr_drive_ctrl: directed test-plan phases plus random button waveforms.
module tb_sr_drive_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 2;
`ifdef SR_DRIVE_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif
   localparam int P    = HOLD + VER;
   localparam int MAXN = 160;

   // event kinds: 0 s rise, 1 r rise, 2 conflict, 3 miss, 4 err rise
   typedef struct {
      int edge_i;
      int kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   sr_drive_if bus();

   sr_drive_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   ev_t exp_q[$];
   bit  ws[MAXN];
   bit  wc[MAXN];
   bit  busy_exp[MAXN];
   bit  err_final;
   bit  qmode = 1'b0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  edge_idx = 0;
   bit  mon_en = 1'b0;

   // SR_FF stand-in; qmode forces a stuck-at-0 read-back.
   logic qff = 1'b0;
   always @(posedge clk) begin
      if (bus.s) qff <= 1'b1;
      else if (bus.r) qff <= 1'b0;
   end
   assign bus.q_fb = qmode ? 1'b0 : qff;

   // A debounced level flips at edge k when the last DEB+1 synchronised samples
   // all show the opposite value; the sample seen at edge k is the button at k-2.
   function automatic void find_reqs(input bit w[MAXN], input int n, output bit req[MAXN]);
      bit lvl = 1'b0;
      for (int k = 0; k < MAXN; k++) req[k] = 1'b0;
      for (int k = 0; k < n; k++) begin
         bit v = ~lvl;
         bit all_v = 1'b1;
         for (int j = k - DEB; j <= k; j++) begin
            bit xj = (j >= 2) ? w[j-2] : 1'b0;
            if (xj != v) all_v = 1'b0;
         end
         if (all_v) begin
            lvl = v;
            if (v && (k + 1 < n)) req[k+1] = 1'b1;
         end
      end
   endfunction

   function automatic void build_expect(input int n);
      bit       rs[MAXN];
      bit       rc[MAXN];
      bit [4:0] evm[MAXN];
      int       free_at = 0;
      bit       err_seen = 1'b0;
      find_reqs(ws, n, rs);
      find_reqs(wc, n, rc);
      err_final = 1'b0;
      for (int k = 0; k < MAXN; k++) begin
         evm[k] = '0;
         busy_exp[k] = 1'b0;
      end
      for (int j = 0; j < n; j++) begin
         if (!(rs[j] || rc[j])) continue;
         if (j < free_at) begin
            evm[j][3] = 1'b1;
         end else if (rs[j] && rc[j]) begin
            evm[j][2] = 1'b1;
         end else begin
            evm[j][rs[j] ? 0 : 1] = 1'b1;
            for (int t = j; t < j + P; t++) if (t < n) busy_exp[t] = 1'b1;
            free_at = j + P + 1;
            if (VER == 1 && rs[j] && qmode && !err_seen && (j + P < n)) begin
               err_seen  = 1'b1;
               err_final = 1'b1;
               evm[j+P][4] = 1'b1;
            end
         end
      end
      for (int k = 0; k < n; k++)
         for (int b = 0; b < 5; b++)
            if (evm[k][b]) exp_q.push_back('{edge_i: k, kind: b});
   endfunction

   task automatic check_ev(input int k, input int kind);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event: got kind %0d at edge %0d, expected no event", kind, k);
      end else begin
         e = exp_q.pop_front();
         if (e.edge_i != k || e.kind != kind) begin
            n_fail++;
            $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                     kind, k, e.kind, e.edge_i);
         end
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      bit ps = 1'b0, pr = 1'b0, perr = 1'b0;
      int srun = 0, rrun = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (bus.s && !ps) check_ev(edge_idx, 0);
            if (bus.r && !pr) check_ev(edge_idx, 1);
            if (bus.conflict) check_ev(edge_idx, 2);
            if (bus.miss) check_ev(edge_idx, 3);
            if (bus.err && !perr) check_ev(edge_idx, 4);
            n_checks++;
            if (bus.busy !== busy_exp[edge_idx]) begin
               n_fail++;
               $display("FAIL busy: edge %0d got %b expected %b", edge_idx, bus.busy, busy_exp[edge_idx]);
            end
            n_checks++;
            if ((bus.s & bus.r) !== 1'b0) begin
               n_fail++;
               $display("FAIL s_r_exclusive: edge %0d got s=%b r=%b expected not both", edge_idx, bus.s, bus.r);
            end
            if (!bus.s && ps) begin
               n_checks++;
               if (srun != HOLD) begin
                  n_fail++;
                  $display("FAIL s_width: got %0d expected %0d", srun, HOLD);
               end
            end
            if (!bus.r && pr) begin
               n_checks++;
               if (rrun != HOLD) begin
                  n_fail++;
                  $display("FAIL r_width: got %0d expected %0d", rrun, HOLD);
               end
            end
            srun = bus.s ? srun + 1 : 0;
            rrun = bus.r ? rrun + 1 : 0;
            ps = bus.s;
            pr = bus.r;
            perr = bus.err;
         end else begin
            ps = 1'b0; pr = 1'b0; perr = 1'b0;
            srun = 0; rrun = 0;
         end
      end
   end

   function automatic void set_wave(input int s_on, input int s_off, input int c_on, input int c_off);
      for (int k = 0; k < MAXN; k++) begin
         ws[k] = (k >= s_on) && (k < s_off);
         wc[k] = (k >= c_on) && (k < c_off);
      end
   endfunction

   function automatic void rand_wave(input int n);
      int k = 0;
      while (k < n) begin
         int len = $urandom_range(1, 14);
         bit v = 1'($urandom_range(0, 1));
         for (int t = 0; t < len && k < n; t++) begin ws[k] = v; k++; end
      end
      k = 0;
      while (k < n) begin
         int len = $urandom_range(1, 14);
         bit v = 1'($urandom_range(0, 1));
         for (int t = 0; t < len && k < n; t++) begin wc[k] = v; k++; end
      end
   endfunction

   // Entered and left on a falling edge; buttons keep their last value through reset.
   task automatic run_phase(input int n, input string name);
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.s, bus.r, bus.busy, bus.conflict, bus.miss, bus.err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state(%s): got s,r,busy,conflict,miss,err=%b expected 000000", name,
                  {bus.s, bus.r, bus.busy, bus.conflict, bus.miss, bus.err});
      end
      @(posedge clk);
      build_expect(n);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         bus.set_btn = ws[k];
         bus.clr_btn = wc[k];
         edge_idx = k;
         mon_en = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_events(%s): got none, expected %0d more, first kind %0d at edge %0d",
                  name, exp_q.size(), exp_q[0].kind, exp_q[0].edge_i);
         exp_q.delete();
      end
      n_checks++;
      if (bus.err !== err_final) begin
         n_fail++;
         $display("FAIL err_sticky(%s): got %b expected %b", name, bus.err, err_final);
      end
   endtask

   initial begin
      bus.set_btn = 1'b0;
      bus.clr_btn = 1'b0;
      @(negedge clk);

      qmode = 1'b0; set_wave(0, MAXN, MAXN, MAXN);  run_phase(30, "set_cmd");
      qmode = 1'b0; set_wave(MAXN, MAXN, 0, 3);     run_phase(30, "glitch");
      qmode = 1'b0; set_wave(3, 20, 3, 20);         run_phase(30, "simultaneous");
      qmode = 1'b0; set_wave(2, 25, 0, 25);         run_phase(30, "press_busy");
      qmode = 1'b1; set_wave(0, MAXN, MAXN, MAXN);  run_phase(30, "failed_write");
      qmode = 1'b0; set_wave(0, MAXN, MAXN, MAXN);  run_phase(8, "reset_mid_cmd");
      qmode = 1'b0; set_wave(0, MAXN, MAXN, MAXN);  run_phase(30, "after_reset");

      for (int i = 0; i < 20; i++) begin
         qmode = ($urandom_range(0, 3) == 0);
         rand_wave(150);
         run_phase(150, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
